dmem_responder: RTL

- Data-memory responder for the single-core RISC-V datapath. It sits on the core's data-memory interface, which carries read/write strobes, a 9-bit byte address, and write/read data.
- Serves byte, halfword and word loads and stores, with sign or zero extension selected by Funct3.
- Inserts a configurable number of wait states and raises a busy/stall signal so the pipeline holds.
- Flags misaligned or illegal accesses and never commits them to memory.

---
 rtl/dmem_pkg.sv | 25 ++
 rtl/dmem_lane_align.sv | 85 ++++++++
 rtl/dmem_responder.sv | 132 +++++++++++++
 3 files changed

// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory responder.
// Funct3 encodings, FSM states and the request kind latched at accept time.
package dmem_pkg;

  localparam int LANES = 4;

  localparam logic [2:0] F3_B  = 3'd0;
  localparam logic [2:0] F3_H  = 3'd1;
  localparam logic [2:0] F3_W  = 3'd2;
  localparam logic [2:0] F3_BU = 3'd4;
  localparam logic [2:0] F3_HU = 3'd5;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    OP_LOAD  = 2'd0,
    OP_STORE = 2'd1,
    OP_BOTH  = 2'd2
  } op_t;

endpackage

// File: rtl/dmem_lane_align.sv
// Combinational lane steering: byte enables and replicated store data,
// load extraction/extension, and the misaligned/illegal access flag.
module dmem_lane_align
  import dmem_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic [1:0]        offset,
  input  logic [2:0]        funct3,
  input  logic [1:0]        op,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [DATA_W-1:0] raw_word,
  output logic [LANES-1:0]  byte_en,
  output logic [DATA_W-1:0] st_data,
  output logic [DATA_W-1:0] ld_data,
  output logic              err
);

  function automatic logic [DATA_W-1:0] ext8(input logic [7:0] b, input logic sgn);
    logic signed [7:0]        bs;
    logic signed [DATA_W-1:0] wide;
    bs   = b;
    wide = bs;
    return sgn ? wide : {{(DATA_W-8){1'b0}}, b};
  endfunction

  function automatic logic [DATA_W-1:0] ext16(input logic [15:0] h, input logic sgn);
    logic signed [15:0]       hs;
    logic signed [DATA_W-1:0] wide;
    hs   = h;
    wide = hs;
    return sgn ? wide : {{(DATA_W-16){1'b0}}, h};
  endfunction

  logic        is_load;
  logic        is_store;
  logic        misalign;
  logic        illegal;
  logic [7:0]  sel_byte;
  logic [15:0] sel_half;

  always_comb begin
    is_load  = (op == OP_LOAD);
    is_store = (op == OP_STORE);
    misalign = ((funct3 == F3_H || funct3 == F3_HU) && offset[0]) ||
               ((funct3 == F3_W) && (offset != 2'd0));
    case (op)
      OP_LOAD:  illegal = !(funct3 inside {F3_B, F3_H, F3_W, F3_BU, F3_HU});
      OP_STORE: illegal = !(funct3 inside {F3_B, F3_H, F3_W});
      default:  illegal = 1'b1;
    endcase
    err = misalign || illegal;

    // Store path: replicate the datum across lanes, enables pick the lanes
    byte_en = '0;
    st_data = wr_data;
    if (is_store && !err) begin
      case (funct3)
        F3_B: begin
          byte_en = LANES'(1) << offset;
          st_data = {(DATA_W/8){wr_data[7:0]}};
        end
        F3_H: begin
          byte_en = offset[1] ? 4'b1100 : 4'b0011;
          st_data = {(DATA_W/16){wr_data[15:0]}};
        end
        default: byte_en = 4'b1111;
      endcase
    end

    sel_byte = raw_word[{offset, 3'b000} +: 8];
    sel_half = offset[1] ? raw_word[31:16] : raw_word[15:0];
    ld_data  = '0;
    if (is_load && !err) begin
      case (funct3)
        F3_B:    ld_data = ext8(sel_byte, 1'b1);
        F3_BU:   ld_data = ext8(sel_byte, 1'b0);
        F3_H:    ld_data = ext16(sel_half, 1'b1);
        F3_HU:   ld_data = ext16(sel_half, 1'b0);
        default: ld_data = raw_word;
      endcase
    end
  end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: accepts one load/store at a time, holds the core
// with busy through WAIT_CYCLES wait states, then pulses done with the result.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int DATA_W      = 32,
  parameter int ADDR_W      = 9,
  parameter int WAIT_CYCLES = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              MemRead,
  input  logic              MemWrite,
  input  logic [ADDR_W-1:0] addr,
  input  logic [2:0]        Funct3,
  input  logic [DATA_W-1:0] wr_data,
  output logic [DATA_W-1:0] rd_data,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam int DEPTH = 2 ** (ADDR_W - 2);

  state_t            state;
  state_t            state_nxt;
  logic [3:0]        cnt;
  logic              req;
  logic              accept;
  logic              access;

  logic [ADDR_W-1:0] addr_q;
  logic [2:0]        f3_q;
  logic [DATA_W-1:0] wdata_q;
  op_t               op_q;

  logic [LANES-1:0]  byte_en;
  logic [DATA_W-1:0] st_data;
  logic [DATA_W-1:0] ld_data;
  logic [DATA_W-1:0] raw_word;
  logic              align_err;

  logic [DATA_W-1:0] mem [DEPTH];

  always_comb begin
    req       = MemRead || MemWrite;
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    accept    = 1'b0;
    access    = 1'b0;
    case (state)
      IDLE: begin
        if (req) begin
          busy      = 1'b1;
          accept    = 1'b1;
          state_nxt = WAIT;
        end
      end
      WAIT: begin
        busy = 1'b1;
        if (cnt == 4'd0) begin
          access    = 1'b1;
          state_nxt = RESP;
        end
      end
      RESP: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      cnt     <= '0;
      rd_data <= '0;
      err     <= 1'b0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        cnt <= 4'(WAIT_CYCLES);
      end else if (state == WAIT && cnt != 4'd0) begin
        cnt <= cnt - 4'd1;
      end
      if (access) begin
        rd_data <= ld_data;
        err     <= align_err;
      end
    end
  end

  // Request fields are captured once at accept; the core may drop them later
  always_ff @(posedge clk) begin
    if (accept) begin
      addr_q  <= addr;
      f3_q    <= Funct3;
      wdata_q <= wr_data;
      op_q    <= (MemRead && MemWrite) ? OP_BOTH : (MemRead ? OP_LOAD : OP_STORE);
    end
  end

  assign raw_word = mem[addr_q[ADDR_W-1:2]];

  dmem_lane_align #(
    .DATA_W (DATA_W)
  ) u_align (
    .offset   (addr_q[1:0]),
    .funct3   (f3_q),
    .op       (op_q),
    .wr_data  (wdata_q),
    .raw_word (raw_word),
    .byte_en  (byte_en),
    .st_data  (st_data),
    .ld_data  (ld_data),
    .err      (align_err)
  );

  // Reset wins over a pending access so an interrupted store never lands
  always_ff @(posedge clk) begin
    if (access && !reset) begin
      for (int l = 0; l < LANES; l++) begin
        if (byte_en[l]) begin
          mem[addr_q[ADDR_W-1:2]][l*8 +: 8] <= st_data[l*8 +: 8];
        end
      end
    end
  end

endmodule
